// File: rtl/mem_responder_if.sv
// Request/response bundle between a requester (cache memory port) and mem_responder.
`default_nettype none

interface mem_responder_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_rd;
    logic             mem_wr;
    logic [31:0]      mem_rdata;
    logic             mem_ready;
    logic             busy;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] wr_count;

    modport master (
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata, mem_ready, busy, rd_count, wr_count
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata, mem_ready, busy, rd_count, wr_count
    );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// mem_responder: word-addressed backing RAM answering rd/wr requests after a fixed
// latency, with a one-cycle ready strobe and read/write access counters.
`default_nettype none

module mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4,
    parameter int CNT_W      = 32
) (
    input  wire logic            clk,
    input  wire logic            reset,
    mem_responder_if.slave       bus
);
    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [7:0]  CNT_LAT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [7:0]              cnt_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic                    rd_q;
    logic                    wr_q;
    logic [31:0]             rdata_q;
    logic                    ready_q;
    logic                    busy_q;
    logic [CNT_W-1:0]        rd_count_q;
    logic [CNT_W-1:0]        wr_count_q;
    logic [31:0]             ram_q [0:DEPTH-1];

    logic                    w_complete;
    logic                    w_unused_addr;

    assign w_complete    = (state_q == S_BUSY) && (cnt_q == 8'd0);
    // Byte-offset and out-of-range address bits are deliberately ignored (aliasing).
    assign w_unused_addr = ^{bus.mem_addr[31:DEPTH_LOG2+2], bus.mem_addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            rdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.mem_rd || bus.mem_wr) begin
                        idx_q   <= bus.mem_addr[DEPTH_LOG2+1:2];
                        wdata_q <= bus.mem_wdata;
                        rd_q    <= bus.mem_rd;
                        wr_q    <= bus.mem_wr;
                        cnt_q   <= CNT_LAT;
                        busy_q  <= 1'b1;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= S_DONE;
                        // Write wins when both are set; the read port echoes the written word.
                        if (wr_q) begin
                            rdata_q    <= wdata_q;
                            wr_count_q <= wr_count_q + CNT_W'(1);
                        end else if (rd_q) begin
                            rdata_q    <= ram_q[idx_q];
                            rd_count_q <= rd_count_q + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Storage is not reset; reset forces the FSM out of BUSY so no write can land.
    always_ff @(posedge clk) begin
        if (w_complete && wr_q) begin
            ram_q[idx_q] <= wdata_q;
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.rd_count  = rd_count_q;
    assign bus.wr_count  = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// Randomised and directed bench for mem_responder, checked against a
// transaction-level model (elapsed-cycle timeline plus associative memory).
`default_nettype none

module tb_mem_responder;
    localparam int L4 = 4;
    localparam int L1 = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_responder_if #(.CNT_W(32)) b4();
    mem_responder_if #(.CNT_W(32)) b1();

    mem_responder #(.DEPTH_LOG2(10), .LATENCY(L4), .CNT_W(32)) dut4 (
        .clk(clk), .reset(reset), .bus(b4)
    );
    mem_responder #(.DEPTH_LOG2(10), .LATENCY(L1), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model for dut4 ----------------
    logic [31:0] m_mem [int unsigned];
    bit          m_inflight = 1'b0;
    int          m_k        = 0;
    bit          m_rd, m_wr;
    int unsigned m_idx;
    logic [31:0] m_wdata;
    logic        exp_ready = 1'b0;
    logic        exp_busy  = 1'b0;
    logic [31:0] exp_rdata = 32'd0;
    logic [31:0] exp_rdc   = 32'd0;
    logic [31:0] exp_wrc   = 32'd0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_inflight = 1'b0;
            exp_ready  = 1'b0;
            exp_busy   = 1'b0;
            exp_rdata  = 32'd0;
            exp_rdc    = 32'd0;
            exp_wrc    = 32'd0;
        end else if (!m_inflight) begin
            if (b4.mem_rd || b4.mem_wr) begin
                m_inflight = 1'b1;
                m_k        = 0;
                m_rd       = b4.mem_rd;
                m_wr       = b4.mem_wr;
                m_idx      = (b4.mem_addr / 4) % 1024;
                m_wdata    = b4.mem_wdata;
                exp_busy   = 1'b1;
            end
        end else begin
            m_k++;
            exp_ready = (m_k == L4);
            if (m_k == L4) begin
                if (m_wr) begin
                    m_mem[m_idx] = m_wdata;
                    exp_rdata    = m_wdata;
                    exp_wrc      = exp_wrc + 1;
                end else begin
                    exp_rdata = m_mem[m_idx];
                    exp_rdc   = exp_rdc + 1;
                end
            end
            if (m_k == L4 + 1) begin
                m_inflight = 1'b0;
                exp_busy   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready",    64'(b4.mem_ready), 64'(exp_ready));
        chk("busy",     64'(b4.busy),      64'(exp_busy));
        chk("rdata",    64'(b4.mem_rdata), 64'(exp_rdata));
        chk("rd_count", 64'(b4.rd_count),  64'(exp_rdc));
        chk("wr_count", 64'(b4.wr_count),  64'(exp_wrc));
    end

    // ---------------- requester for dut4 ----------------
    task automatic req(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit scramble,
                       output int lat, output logic [31:0] rdata);
        int c0;
        bit seen;
        @(negedge clk);
        b4.mem_addr  = addr;
        b4.mem_wdata = wdata;
        b4.mem_rd    = rd;
        b4.mem_wr    = wr;
        c0   = cyc + 1;
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (b4.mem_ready) seen = 1'b1;
            else if (scramble) begin
                b4.mem_addr  = $urandom;
                b4.mem_wdata = $urandom;
            end
        end
        chk("handshake_timeout", 64'(!seen), 64'd0);
        lat   = cyc - c0;
        rdata = b4.mem_rdata;
        b4.mem_rd = 1'b0;
        b4.mem_wr = 1'b0;
    endtask

    int          lat;
    logic [31:0] rd_v;
    bit          written [16];

    initial begin
        b4.mem_addr = 32'd0; b4.mem_wdata = 32'd0; b4.mem_rd = 1'b0; b4.mem_wr = 1'b0;
        b1.mem_addr = 32'd0; b1.mem_wdata = 32'd0; b1.mem_rd = 1'b0; b1.mem_wr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rd_count", 64'(b4.rd_count), 64'd0);
        chk("reset_wr_count", 64'(b4.wr_count), 64'd0);
        chk("reset_busy1",    64'(b1.busy),     64'd0);
        #2 reset = 1'b1;

        // Directed: write then read 0x40; accept edge to ready edge is LATENCY edges.
        req(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, lat, rd_v);
        chk("wr_latency", 64'(lat), 64'd4);
        chk("wr_count1",  64'(b4.wr_count), 64'd1);
        req(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, lat, rd_v);
        chk("rd_latency", 64'(lat), 64'd4);
        chk("rd_0x40",    64'(rd_v), 64'hDEADBEEF);
        chk("rd_count1",  64'(b4.rd_count), 64'd1);

        // Aliasing: 0x1004, 0x4 and 0x6 are the same word.
        req(1'b0, 1'b1, 32'h1004, 32'h11111111, 1'b0, lat, rd_v);
        req(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, lat, rd_v);
        chk("alias_0x4", 64'(rd_v), 64'h11111111);
        req(1'b1, 1'b0, 32'h6, 32'h0, 1'b0, lat, rd_v);
        chk("alias_0x6", 64'(rd_v), 64'h11111111);

        // Both strobes: write wins and is echoed.
        req(1'b1, 1'b1, 32'h80, 32'hA5A5A5A5, 1'b0, lat, rd_v);
        chk("both_rdata", 64'(rd_v), 64'hA5A5A5A5);
        chk("both_wrc",   64'(b4.wr_count), 64'd3);
        chk("both_rdc",   64'(b4.rd_count), 64'd3);
        req(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, lat, rd_v);
        chk("rd_0x80", 64'(rd_v), 64'hA5A5A5A5);

        // Inputs scrambled while busy: the latched access must complete.
        req(1'b0, 1'b1, 32'h100, 32'hCAFEF00D, 1'b1, lat, rd_v);
        req(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, lat, rd_v);
        chk("latched_wr", 64'(rd_v), 64'hCAFEF00D);

        // Reset two cycles into a write to 0xC0 that holds 0.
        req(1'b0, 1'b1, 32'hC0, 32'h0, 1'b0, lat, rd_v);
        @(negedge clk);
        b4.mem_addr = 32'hC0; b4.mem_wdata = 32'h12345678; b4.mem_wr = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("abort_ready", 64'(b4.mem_ready), 64'd0);
        end
        chk("abort_wrc", 64'(b4.wr_count), 64'd0);
        chk("abort_rdc", 64'(b4.rd_count), 64'd0);
        b4.mem_wr = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        req(1'b1, 1'b0, 32'hC0, 32'h0, 1'b0, lat, rd_v);
        chk("abort_rd_0xC0", 64'(rd_v), 64'd0);

        // Randomised traffic over 16 word slots with random alias/byte bits.
        for (int t = 0; t < 150; t++) begin
            int          slot;
            int          kind;
            logic [31:0] a;
            slot = $urandom_range(0, 15);
            kind = $urandom_range(0, 2);
            a    = (($urandom & 32'hFFFF_F000)) | (32'(slot) << 4) | 32'($urandom_range(0, 3));
            if (kind == 0 && !written[slot]) kind = 1;
            if (kind != 0) written[slot] = 1'b1;
            req(kind != 1, kind != 0, a, $urandom, 1'($urandom_range(0, 1)), lat, rd_v);
            chk("rand_latency", 64'(lat), 64'd4);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // LATENCY = 1 instance.
        @(negedge clk);
        b1.mem_addr = 32'h44; b1.mem_wdata = 32'h5A5A0001; b1.mem_wr = 1'b1;
        begin
            int c0;
            c0 = cyc + 1;
            for (int n = 0; n < 20 && !b1.mem_ready; n++) @(negedge clk);
            chk("l1_wr_latency", 64'(cyc - c0), 64'd1);
            b1.mem_wr = 1'b0;
            @(negedge clk);
            chk("l1_pulse_width", 64'(b1.mem_ready), 64'd0);
            b1.mem_addr = 32'h2044; b1.mem_rd = 1'b1;
            c0 = cyc + 1;
            for (int n = 0; n < 20 && !b1.mem_ready; n++) @(negedge clk);
            chk("l1_rd_latency", 64'(cyc - c0), 64'd1);
            chk("l1_rdata",      64'(b1.mem_rdata), 64'h5A5A0001);
            b1.mem_rd = 1'b0;
            @(negedge clk);
            chk("l1_rdc", 64'(b1.rd_count), 64'd1);
            chk("l1_wrc", 64'(b1.wr_count), 64'd1);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end
endmodule

`default_nettype wire
